// File: rtl/dac_ramp_sequencer.sv
// Four-channel DAC code slew sequencer: stages shadow targets, commits them
// atomically, and ramps the presented codes toward them in bounded steps.

module dac_ramp_lane #(
  parameter int STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] target,
  output logic [7:0] cur,
  output logic [7:0] nxt
);
  localparam logic [7:0] S = 8'(STEP);

  // Clamp to target when within one step, so no wrap past 0 or 255.
  always_comb begin
    nxt = cur;
    if (target >= cur)
      nxt = ((target - cur) <= S) ? target : cur + S;
    else
      nxt = ((cur - target) <= S) ? target : cur - S;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cur <= '0;
    else if (tick) cur <= nxt;
  end
endmodule

module dac_ramp_sequencer #(
  parameter int RAMP_DIV    = 12500,
  parameter int STEP        = 1,
  parameter int HOLD_CYCLES = 2560
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic [7:0] dbA,
  output logic [7:0] dbB,
  output logic [7:0] dbC,
  output logic [7:0] dbD,
  output logic       enable_update,
  output logic       busy
);
  localparam int NUM_LANES = 4;
  localparam logic [15:0] DIV_MAX  = 16'(RAMP_DIV - 1);
  localparam logic [15:0] HOLD_MAX = 16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

  state_t state, state_nxt;
  logic [NUM_LANES-1:0][7:0] shadow, target, commit_tgt, cur, nxt;
  logic [15:0] div, hold;
  logic        tick;

  // A write landing on the commit edge bypasses into the committed target.
  always_comb begin
    commit_tgt = shadow;
    if (wr_en) commit_tgt[wr_addr] = wr_data;
  end

  // A commit pre-empts a coincident tick; the divider restarts instead.
  assign tick = (state == RAMP) && (div == DIV_MAX) && !commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      target <= '0;
    end else begin
      if (wr_en)  shadow[wr_addr] <= wr_data;
      if (commit) target <= commit_tgt;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dac_ramp_lane #(.STEP(STEP)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .target (target[i]),
      .cur    (cur[i]),
      .nxt    (nxt[i])
    );
  end

  assign dbA = cur[0];
  assign dbB = cur[1];
  assign dbC = cur[2];
  assign dbD = cur[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      div   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      if (commit) begin
        div  <= '0;
        hold <= '0;
      end else begin
        div  <= (state == RAMP && !tick) ? div + 16'd1 : '0;
        hold <= (state == SETTLE) ? hold + 16'd1 : '0;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    enable_update = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: ;
      RAMP: begin
        enable_update = 1'b1;
        busy          = 1'b1;
        if (tick && (nxt == target)) state_nxt = SETTLE;
      end
      SETTLE: begin
        enable_update = 1'b1;
        busy          = 1'b1;
        if (hold == HOLD_MAX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (commit) state_nxt = (cur != commit_tgt) ? RAMP : SETTLE;
  end
endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// Directed bench for dac_ramp_sequencer with RAMP_DIV=4, STEP=2, HOLD_CYCLES=8.
module tb_dac_ramp_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       commit = 1'b0;
  logic [7:0] dbA, dbB, dbC, dbD;
  logic       enable_update, busy;
  int tests = 0;
  int fails = 0;

  dac_ramp_sequencer #(.RAMP_DIV(4), .STEP(2), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .dbA(dbA), .dbB(dbB), .dbC(dbC),
    .dbD(dbD), .enable_update(enable_update), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cyc(1);
    commit = 1'b0;
  endtask

  task automatic chk_idle_codes(input string tag, input logic [7:0] a, b, c, d);
    chk({tag, "_dbA"}, dbA, a);
    chk({tag, "_dbB"}, dbB, b);
    chk({tag, "_dbC"}, dbC, c);
    chk({tag, "_dbD"}, dbD, d);
  endtask

  initial begin
    cyc(2);
    chk_idle_codes("reset", 0, 0, 0, 0);
    chk("reset_en", enable_update, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: single channel ramp A 0 -> 7
    wr(0, 7);
    chk("wr_no_effect", dbA, 0);
    do_commit();
    chk("t1_busy", busy, 1);
    chk("t1_en", enable_update, 1);
    cyc(3);
    chk("t1_pre_tick", dbA, 0);
    cyc(1); chk("t1_tick1", dbA, 2);
    cyc(4); chk("t1_tick2", dbA, 4);
    cyc(4); chk("t1_tick3", dbA, 6);
    cyc(4); chk("t1_tick4", dbA, 7);
    cyc(7); chk("t1_hold_en", enable_update, 1);
    cyc(1); chk("t1_fall_en", enable_update, 0);
    chk("t1_fall_busy", busy, 0);
    chk_idle_codes("t1_end", 7, 0, 0, 0);

    // 2: all channels differ, from all-zero
    rst_n = 1'b0; cyc(1); rst_n = 1'b1; cyc(1);
    wr(0, 1); wr(1, 255); wr(2, 0); wr(3, 10);
    do_commit();
    cyc(4);
    chk_idle_codes("t2_tick1", 1, 2, 0, 2);
    for (int t = 2; t <= 127; t++) begin
      cyc(4);
      chk("t2_rampB", dbB, 32'(2 * t));
      if (t == 5) chk("t2_D_done", dbD, 10);
    end
    cyc(3); chk("t2_still_busy", busy, 1);
    cyc(1); chk("t2_B_final", dbB, 255);
    cyc(4); chk("t2_B_nowrap", dbB, 255);
    cyc(3); chk("t2_hold_en", enable_update, 1);
    cyc(1); chk("t2_fall_en", enable_update, 0);
    chk_idle_codes("t2_end", 1, 255, 0, 10);

    // 3: ramp A to 200, then reverse mid-ramp from 204 toward 190
    wr(0, 200);
    do_commit();
    cyc(400);
    chk("t3_A200", dbA, 200);
    cyc(8);
    chk("t3_idle", busy, 0);
    wr(0, 210);
    do_commit();
    cyc(8);
    chk("t3_A204", dbA, 204);
    wr(0, 190);
    do_commit();
    for (int k = 1; k <= 7; k++) begin
      cyc(4);
      chk("t3_reverse", dbA, 32'(204 - 2 * k));
    end
    cyc(4);
    chk("t3_no_overshoot", dbA, 190);
    cyc(4);
    chk("t3_idle2", enable_update, 0);

    // 4: null commit -> exactly 8 cycles of enable_update
    do_commit();
    chk("t4_en0", enable_update, 1);
    chk("t4_busy0", busy, 1);
    for (int k = 1; k < 8; k++) begin
      cyc(1);
      chk("t4_en", enable_update, 1);
    end
    cyc(1);
    chk("t4_fall_en", enable_update, 0);
    chk("t4_fall_busy", busy, 0);
    chk_idle_codes("t4_codes", 190, 255, 0, 10);

    // 5: same-cycle write and commit bypass into D
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h55; commit = 1'b1;
    cyc(1);
    wr_en = 1'b0; commit = 1'b0;
    chk("t5_busy", busy, 1);
    cyc(4); chk("t5_D_tick1", dbD, 12);
    cyc(4 * 36); chk("t5_D_84", dbD, 84);
    cyc(4); chk("t5_D_final", dbD, 8'h55);
    cyc(8); chk("t5_idle", enable_update, 0);
    wr(0, 33);
    cyc(50);
    chk("t5_shadow_only_A", dbA, 190);
    chk("t5_shadow_only_en", enable_update, 0);

    // 6: asynchronous reset mid-ramp at dbA=100
    wr(0, 0);
    do_commit();
    cyc(4 * 45);
    chk("t6_A100", dbA, 100);
    rst_n = 1'b0;
    #1;
    chk_idle_codes("t6_async", 0, 0, 0, 0);
    chk("t6_async_en", enable_update, 0);
    chk("t6_async_busy", busy, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(20);
    chk_idle_codes("t6_after", 0, 0, 0, 0);
    chk("t6_after_en", enable_update, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dac_ramp_sequencer.md
Name: dac_ramp_sequencer

Overview:
Upstream stage of the 4-channel parallel DAC writer in the pattern generator. It holds host-programmed 8-bit target codes for channels A-D and slews the codes it presents on dbA..dbD toward those targets in bounded steps, so that sensor bias and threshold DACs never jump. It drives the writer's enable_update level for as long as codes are changing, plus a hold window that covers at least one full DAC write frame.

Parameters:
RAMP_DIV, 12500, clocks between ramp ticks (100 us at 125 MHz); legal range 1..65535.
STEP, 1, maximum code change per channel per tick; legal range 1..255 (255 = jump in one tick).
HOLD_CYCLES, 2560, clocks enable_update stays high after the last code change (one writer frame at default clock divide); legal range 1..65535.

Ports:
clk  in  1  system clock, 125 MHz
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host write strobe, one cycle per write, into the shadow target
wr_addr  in  2  shadow channel select: 0=A, 1=B, 2=C, 3=D
wr_data  in  8  shadow target code
commit  in  1  one-cycle pulse; copies all four shadow targets to the active targets atomically
dbA  out  8  current code, channel A
dbB  out  8  current code, channel B
dbC  out  8  current code, channel C
dbD  out  8  current code, channel D
enable_update  out  1  level request to the DAC writer
busy  out  1  high in RAMP or SETTLE

Behaviour:
- Reset (async assert, sync release): shadow, active and current codes = 0; dbA..dbD = 0; enable_update = 0; busy = 0; divider and hold counters = 0; state = IDLE.
- Shadow write: on wr_en, shadow[wr_addr] <= wr_data. Writes are accepted in every state and never affect outputs until a commit.
- Same-cycle wr_en and commit: the write bypasses into the commit, so the active target takes the new wr_data.
- On commit, all four active targets update on that edge. The divider clears to 0. Next state:
  - RAMP if any current code differs from its active target;
  - otherwise SETTLE, with the hold counter cleared. This forces one refresh.
- IDLE: enable_update = 0, busy = 0. Exits only on commit.
- RAMP:
  - enable_update = 1 and busy = 1 from the cycle after the commit edge.
  - The divider counts 0..RAMP_DIV-1. The tick occurs on the edge where the count equals RAMP_DIV-1, so the first code change is visible RAMP_DIV cycles after the commit edge.
  - On each tick, every channel moves independently: if |target - cur| <= STEP then cur <= target; else cur <= cur +/- STEP.
  - Arithmetic is unsigned 8-bit with no wrap at 0 or 255, guaranteed by the clamp.
  - When all four channels equal their targets after a tick, go to SETTLE with the hold counter cleared.
- SETTLE:
  - enable_update = 1, busy = 1; codes are held.
  - The hold counter counts to HOLD_CYCLES-1, then the block returns to IDLE; enable_update falls on the next cycle.
- Commit during RAMP: targets are replaced, ramping continues from the present codes, the divider restarts, and the direction can reverse.
- Commit during SETTLE: re-evaluated exactly as for a commit from IDLE.
- dbA..dbD are registered copies of the current codes and change only on tick edges. They never change in IDLE or SETTLE.
- Reset asserted mid-ramp: all codes return to 0 immediately and enable_update drops asynchronously.

Test Plan:
1. Bench parameters RAMP_DIV=4, STEP=2, HOLD_CYCLES=8. Write A=7 then commit -> busy rises next cycle; dbA reads 2, 4, 6, 7 at cycles 4, 8, 12, 16 after commit; enable_update stays high through those cycles plus 8 more, then falls; B, C, D stay 0.
2. All channels differ: commit A=1, B=255, C=0, D=10 from all-zero -> D reaches 10 and A reaches 1 first. B takes 128 ticks and ends at exactly 255, with no wrap and never above 255. SETTLE is entered only after B reaches its target.
3. Reversal: after reaching A=200 with STEP=2, write A=190 and commit while another A ramp to 210 is at 204 -> dbA goes 202, 200, ..., 190, with no overshoot below 190.
4. Null commit: commit with targets equal to current codes -> no code change; enable_update high for exactly 8 cycles; busy high for the same window; then IDLE.
5. Same-cycle write and commit: wr_en with addr=3, data=0x55 and commit on the same edge -> dbD ramps toward 0x55. A shadow write without commit -> outputs unchanged indefinitely.
6. Reset mid-ramp: assert rst_n low while dbA=100 -> dbA..dbD=0, enable_update=0, busy=0 asynchronously. After release, outputs stay 0 until the next commit.
